// File: rtl/rf_pkg.sv
// Register-file shared definitions: address/data widths, the $zero index and
// the write record carried from the writeback queue to the register file.
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_wb_collide.sv
// Write-enable filter for one drain group: drops $zero writes and any write
// overtaken by a younger slot of the same group targeting the same register.
module rf_wb_collide
  import rf_pkg::*;
#(
  parameter int WRITE_PORTS = 4,
  parameter int ADDR_WIDTH  = REG_ADDR_W
) (
  input  logic [WRITE_PORTS-1:0] slot_used,
  input  logic [ADDR_WIDTH-1:0]  slot_addr [WRITE_PORTS],
  output logic [WRITE_PORTS-1:0] slot_enable
);

  // per-slot enable: used, not $zero, and not shadowed by a younger slot
  always_comb begin
    logic shadowed;
    shadowed    = 1'b0;
    slot_enable = '0;
    for (int k = 0; k < WRITE_PORTS; k++) begin
      shadowed = 1'b0;
      for (int m = k + 1; m < WRITE_PORTS; m++) begin
        shadowed = shadowed | (slot_used[m] && (slot_addr[m] == slot_addr[k]));
      end
      slot_enable[k] = slot_used[k] && (slot_addr[k] != ADDR_WIDTH'(REG_ZERO)) && !shadowed;
    end
  end

endmodule

// File: rtl/rf_wb_queue_chk.sv
// Protocol checker for rf_wb_queue: producers must hold src_valid until
// accepted, and occupancy never exceeds the queue depth.
module rf_wb_queue_chk #(
  parameter int NSRC  = 4,
  parameter int DEPTH = 8
) (
  input logic                     clock,
  input logic                     reset_n,
  input logic [NSRC-1:0]          src_valid,
  input logic [NSRC-1:0]          src_ready,
  input logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;

  for (genvar i = 0; i < NSRC; i++) begin : g_hold
    a_valid_hold: assert property (@(posedge clock) disable iff (!reset_n)
      (src_valid[i] && !src_ready[i]) |=> src_valid[i]);
  end

  a_count_bound: assert property (@(posedge clock) disable iff (!reset_n)
    count <= CW'(DEPTH));

endmodule

// File: rtl/rf_wb_queue.sv
// In-order writeback queue feeding the register-file write ports.
// Optional operand bypass lookup is built when RF_WB_QUEUE_BYPASS_EN is defined.
module rf_wb_queue
  import rf_pkg::*;
#(
  parameter int NSRC        = 4,
  parameter int DEPTH       = 8,
  parameter int ADDR_WIDTH  = REG_ADDR_W,
  parameter int DATA_WIDTH  = REG_DATA_W,
  parameter int WRITE_PORTS = 4
`ifdef RF_WB_QUEUE_BYPASS_EN
  ,
  parameter int NLOOKUP     = 8
`endif
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NSRC-1:0]        src_valid,
  output logic [NSRC-1:0]        src_ready,
  input  logic [ADDR_WIDTH-1:0]  src_addr [NSRC],
  input  logic [DATA_WIDTH-1:0]  src_data [NSRC],
  input  logic                   drain_hold,
  output logic [ADDR_WIDTH-1:0]  wr_addr [WRITE_PORTS],
  output logic [WRITE_PORTS-1:0] wr_enable,
  output logic [DATA_WIDTH-1:0]  wr_data [WRITE_PORTS],
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
`ifdef RF_WB_QUEUE_BYPASS_EN
  ,
  input  logic [ADDR_WIDTH-1:0]  lk_addr [NLOOKUP],
  output logic [NLOOKUP-1:0]     lk_hit,
  output logic [DATA_WIDTH-1:0]  lk_data [NLOOKUP]
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  rf_wr_t entries_r [DEPTH];
  ptr_t   head_r;
  ptr_t   tail_r;
  cnt_t   count_r;

  cnt_t                   free_s;
  cnt_t                   n_acc_s;
  cnt_t                   n_drain_s;
  logic [NSRC-1:0]        acc_s;
  ptr_t                   slot_s [NSRC];
  logic [WRITE_PORTS-1:0] used_s;

  // Readiness from start-of-cycle occupancy only; accepted ports pack at tail in port order.
  always_comb begin
    free_s    = cnt_t'(DEPTH) - count_r;
    n_acc_s   = '0;
    src_ready = '0;
    acc_s     = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_ready[i] = reset_n && (free_s >= cnt_t'(i + 1));
      acc_s[i]     = src_valid[i] && src_ready[i];
      slot_s[i]    = tail_r + ptr_t'(n_acc_s);
      n_acc_s      = n_acc_s + cnt_t'(acc_s[i]);
    end
  end

  // Present the oldest entries on the write ports; unused ports stay at zero.
  always_comb begin
    rf_wr_t e;
    e = '0;
    if (!reset_n || drain_hold) begin
      n_drain_s = '0;
    end else if (count_r < cnt_t'(WRITE_PORTS)) begin
      n_drain_s = count_r;
    end else begin
      n_drain_s = cnt_t'(WRITE_PORTS);
    end
    used_s = '0;
    for (int k = 0; k < WRITE_PORTS; k++) begin
      e          = entries_r[head_r + ptr_t'(k)];
      used_s[k]  = cnt_t'(k) < n_drain_s;
      wr_addr[k] = used_s[k] ? ADDR_WIDTH'(e.addr) : '0;
      wr_data[k] = used_s[k] ? DATA_WIDTH'(e.data) : '0;
    end
  end

  rf_wb_collide #(
    .WRITE_PORTS (WRITE_PORTS),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_collide (
    .slot_used   (used_s),
    .slot_addr   (wr_addr),
    .slot_enable (wr_enable)
  );

  // Pointer and occupancy update; reset discards everything queued.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + ptr_t'(n_drain_s);
      tail_r  <= tail_r + ptr_t'(n_acc_s);
      count_r <= count_r + n_acc_s - n_drain_s;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NSRC; i++) begin
      if (acc_s[i]) begin
        entries_r[slot_s[i]] <= {REG_ADDR_W'(src_addr[i]), REG_DATA_W'(src_data[i])};
      end
    end
  end

  assign count = count_r;
  assign empty = (count_r == '0);

`ifdef RF_WB_QUEUE_BYPASS_EN
  // Oldest-to-youngest scan so the youngest matching entry wins.
  always_comb begin
    rf_wr_t e;
    logic   match;
    e       = '0;
    match   = 1'b0;
    lk_hit  = '0;
    for (int l = 0; l < NLOOKUP; l++) begin
      lk_data[l] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        e          = entries_r[head_r + ptr_t'(j)];
        match      = reset_n && (cnt_t'(j) < count_r) &&
                     (lk_addr[l] != ADDR_WIDTH'(REG_ZERO)) &&
                     (ADDR_WIDTH'(e.addr) == lk_addr[l]);
        lk_hit[l]  = lk_hit[l] | match;
        lk_data[l] = match ? DATA_WIDTH'(e.data) : lk_data[l];
      end
    end
  end
`endif

  rf_wb_queue_chk #(
    .NSRC  (NSRC),
    .DEPTH (DEPTH)
  ) u_chk (
    .clock     (clock),
    .reset_n   (reset_n),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .count     (count_r)
  );

endmodule

// File: tb/tb_rf_wb_queue.sv
// Randomized bench for rf_wb_queue against a queue-based reference model.
module tb_rf_wb_queue;

  logic       clock;
  logic       reset_n;
  logic [3:0] src_valid;
  logic [3:0] src_ready;
  logic [4:0] src_addr [4];
  logic [31:0] src_data [4];
  logic       drain_hold;
  logic [4:0] wr_addr [4];
  logic [3:0] wr_enable;
  logic [31:0] wr_data [4];
  logic [3:0] count;
  logic       empty;
`ifdef RF_WB_QUEUE_BYPASS_EN
  logic [4:0]  lk_addr [8];
  logic [7:0]  lk_hit;
  logic [31:0] lk_data [8];
`endif

  rf_wb_queue dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .drain_hold (drain_hold),
    .wr_addr    (wr_addr),
    .wr_enable  (wr_enable),
    .wr_data    (wr_data),
    .count      (count),
    .empty      (empty)
`ifdef RF_WB_QUEUE_BYPASS_EN
    ,
    .lk_addr    (lk_addr),
    .lk_hit     (lk_hit),
    .lk_data    (lk_data)
`endif
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [3:0]  pv;
  logic [4:0]  pa [4];
  logic [31:0] pd [4];
  logic [31:0] ref_rf [32];
  logic [31:0] dut_rf [32];
  int          n_cmp;
  int          n_err;

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refill(input int vpct, input int amax);
    for (int i = 0; i < 4; i++) begin
      if (!pv[i] && $urandom_range(0, 99) < vpct) begin
        pv[i] = 1'b1;
        pa[i] = 5'($urandom_range(0, amax));
        pd[i] = $urandom;
      end
    end
  endtask

  // Drive one cycle, check outputs mid-cycle, then advance the model.
  task automatic run_cycle(input logic hold, input logic rst);
    int         sz;
    int         n;
    logic [3:0] exp_rdy;
    logic [4:0] ea;
    logic [31:0] ed;
    logic       ee;
    ent_t       e;
    reset_n    = rst;
    drain_hold = hold;
    for (int i = 0; i < 4; i++) begin
      src_valid[i] = pv[i] & rst;
      src_addr[i]  = pa[i];
      src_data[i]  = pd[i];
    end
`ifdef RF_WB_QUEUE_BYPASS_EN
    for (int l = 0; l < 8; l++) lk_addr[l] = 5'($urandom_range(0, 7));
`endif
    @(negedge clock);
    sz = mq.size();
    for (int i = 0; i < 4; i++) exp_rdy[i] = rst && ((8 - sz) >= i + 1);
    check_eq("src_ready", 64'(src_ready), 64'(exp_rdy));
    check_eq("count", 64'(count), 64'(sz));
    check_eq("empty", 64'(empty), 64'(sz == 0));
    n = (!rst || hold) ? 0 : ((sz < 4) ? sz : 4);
    for (int k = 0; k < 4; k++) begin
      ea = (k < n) ? mq[k].a : 5'd0;
      ed = (k < n) ? mq[k].d : 32'd0;
      ee = (k < n) && (ea != 5'd0);
      for (int m = k + 1; m < n; m++) begin
        if (mq[m].a == ea) ee = 1'b0;
      end
      check_eq($sformatf("wr_addr%0d", k), 64'(wr_addr[k]), 64'(ea));
      check_eq($sformatf("wr_data%0d", k), 64'(wr_data[k]), 64'(ed));
      check_eq($sformatf("wr_enable%0d", k), 64'(wr_enable[k]), 64'(ee));
    end
    for (int k = 0; k < 4; k++) begin
      if (wr_enable[k]) dut_rf[wr_addr[k]] = wr_data[k];
    end
`ifdef RF_WB_QUEUE_BYPASS_EN
    for (int l = 0; l < 8; l++) begin
      logic        eh;
      logic [31:0] eld;
      eh  = 1'b0;
      eld = 32'd0;
      if (rst && lk_addr[l] != 5'd0) begin
        for (int j = 0; j < sz; j++) begin
          if (mq[j].a == lk_addr[l]) begin
            eh  = 1'b1;
            eld = mq[j].d;
          end
        end
      end
      check_eq($sformatf("lk_hit%0d", l), 64'(lk_hit[l]), 64'(eh));
      check_eq($sformatf("lk_data%0d", l), 64'(lk_data[l]), 64'(eld));
    end
`endif
    if (!rst) begin
      mq.delete();
      pv = 4'b0000;
    end else begin
      for (int k = 0; k < n; k++) begin
        e = mq.pop_front();
        if (e.a != 5'd0) ref_rf[e.a] = e.d;
      end
      for (int i = 0; i < 4; i++) begin
        if (pv[i] && exp_rdy[i]) begin
          mq.push_back('{a: pa[i], d: pd[i]});
          pv[i] = 1'b0;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int hp;
    int vp;
    clock      = 1'b0;
    reset_n    = 1'b0;
    drain_hold = 1'b0;
    src_valid  = 4'b0000;
    pv         = 4'b0000;
    n_cmp      = 0;
    n_err      = 0;
    for (int i = 0; i < 4; i++) begin
      pa[i] = 5'd0;
      pd[i] = 32'd0;
    end
    for (int r = 0; r < 32; r++) begin
      ref_rf[r] = 32'd0;
      dut_rf[r] = 32'd0;
    end
    @(posedge clock);
    #1;
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b0, 1'b0);

    // four producers at once, presented next cycle, gone the one after
    pv = 4'b1111;
    pa = '{5'd1, 5'd2, 5'd3, 5'd4};
    pd = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int c = 0; c < 3; c++) run_cycle(1'b0, 1'b1);

    // fill to full under hold, then release
    for (int c = 0; c < 4; c++) begin
      refill(100, 31);
      run_cycle(1'b1, 1'b1);
    end
    for (int c = 0; c < 5; c++) run_cycle(1'b0, 1'b1);

    // same-address and $zero collision inside one drain group
    pv = 4'b1111;
    pa = '{5'd5, 5'd5, 5'd0, 5'd7};
    pd = '{32'hA, 32'hB, 32'hC, 32'hD};
    run_cycle(1'b1, 1'b1);
    run_cycle(1'b0, 1'b1);
    run_cycle(1'b0, 1'b1);

    // randomized traffic with varying pressure, wrap-around and mid-run resets
    for (int c = 0; c < 400; c++) begin
      case ((c / 40) % 4)
        0:       begin hp = 0;  vp = 60;  end
        1:       begin hp = 50; vp = 90;  end
        2:       begin hp = 90; vp = 100; end
        default: begin hp = 20; vp = 30;  end
      endcase
      refill(vp, ((c % 3) == 0) ? 31 : 7);
      run_cycle($urandom_range(0, 99) < hp, !(c == 150 || c == 290));
    end
    for (int c = 0; c < 6; c++) run_cycle(1'b0, 1'b1);

    for (int r = 0; r < 32; r++) check_eq($sformatf("rf%0d", r), 64'(dut_rf[r]), 64'(ref_rf[r]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
